// File: rtl/dec_rv_ssc_bundler_pkg.sv
// Shared decode definitions for the superscalar issue bundler: queue depth default,
// RV32 opcode classes and the lane-count / bundle-state encodings.
package dec_rv_ssc_bundler_pkg;

   localparam int QDEPTH_DEF = 4;

   // opcode[6:2] values
   localparam logic [4:0] OPC_BRANCH = 5'b11000;
   localparam logic [4:0] OPC_JALR   = 5'b11001;
   localparam logic [4:0] OPC_JAL    = 5'b11011;
   localparam logic [4:0] OPC_SYSTEM = 5'b11100;
   localparam logic [4:0] OPC_STORE  = 5'b01000;
   localparam logic [4:0] OPC_LUI    = 5'b01101;
   localparam logic [4:0] OPC_AUIPC  = 5'b00101;
   localparam logic [4:0] OPC_OP     = 5'b01100;

   typedef enum logic [1:0] {
      CNT_NONE  = 2'd0,
      CNT_ONE   = 2'd1,
      CNT_TWO   = 2'd2,
      CNT_THREE = 2'd3
   } lane_cnt_e;

   typedef enum logic {
      ST_EMPTY = 1'b0,
      ST_HELD  = 1'b1
   } bundle_state_e;

   function automatic logic is_ctrl(input logic [4:0] opc);
      return opc inside {OPC_BRANCH, OPC_JALR, OPC_JAL, OPC_SYSTEM};
   endfunction

   function automatic logic writes_rd(input logic [4:0] opc);
      return !(opc inside {OPC_BRANCH, OPC_STORE});
   endfunction

   function automatic logic reads_rs1(input logic [4:0] opc);
      return !(opc inside {OPC_LUI, OPC_AUIPC, OPC_JAL});
   endfunction

   function automatic logic reads_rs2(input logic [4:0] opc);
      return opc inside {OPC_OP, OPC_BRANCH, OPC_STORE};
   endfunction

endpackage

// File: rtl/dec_rv_ssc_bundler_pair_chk.sv
// Register-hazard checker for a candidate bundle A,B,C (program order).
// Flags: bit0 RAW A->B, bit1 WAW A/B, bit2 RAW into C, bit3 WAW involving C.
module dec_rv_ssc_pair_chk
   import dec_rv_ssc_bundler_pkg::*;
(
   input  logic [31:0] i_word_a,
   input  logic [31:0] i_word_b,
   input  logic [31:0] i_word_c,
   output logic [3:0]  o_block
);

   logic [31:0] w_word [3];
   logic [4:0]  w_rd   [3];
   logic [4:0]  w_rs1  [3];
   logic [4:0]  w_rs2  [3];
   logic        w_wr   [3];
   logic        w_r1   [3];
   logic        w_r2   [3];

   assign w_word[0] = i_word_a;
   assign w_word[1] = i_word_b;
   assign w_word[2] = i_word_c;

   for (genvar g = 0; g < 3; g++) begin : g_dec
      logic w_unused_bits;
      assign w_rd[g]  = w_word[g][11:7];
      assign w_rs1[g] = w_word[g][19:15];
      assign w_rs2[g] = w_word[g][24:20];
      // x0 is never a real destination, so it cannot create a hazard
      assign w_wr[g]  = writes_rd(w_word[g][6:2]) && (w_word[g][11:7] != 5'd0);
      assign w_r1[g]  = reads_rs1(w_word[g][6:2]);
      assign w_r2[g]  = reads_rs2(w_word[g][6:2]);
      assign w_unused_bits = ^{w_word[g][31:25], w_word[g][14:12], w_word[g][1:0]};
   end

   function automatic logic raw_hz(input logic wr_p, input logic [4:0] rd_p,
                                   input logic r1_c, input logic [4:0] rs1_c,
                                   input logic r2_c, input logic [4:0] rs2_c);
      return wr_p && ((r1_c && (rs1_c == rd_p)) || (r2_c && (rs2_c == rd_p)));
   endfunction

   function automatic logic waw_hz(input logic wr_p, input logic [4:0] rd_p,
                                   input logic wr_c, input logic [4:0] rd_c);
      return wr_p && wr_c && (rd_p == rd_c);
   endfunction

   assign o_block[0] = raw_hz(w_wr[0], w_rd[0], w_r1[1], w_rs1[1], w_r2[1], w_rs2[1]);
   assign o_block[1] = waw_hz(w_wr[0], w_rd[0], w_wr[1], w_rd[1]);
   assign o_block[2] = raw_hz(w_wr[0], w_rd[0], w_r1[2], w_rs1[2], w_r2[2], w_rs2[2])
                     | raw_hz(w_wr[1], w_rd[1], w_r1[2], w_rs1[2], w_r2[2], w_rs2[2]);
   assign o_block[3] = waw_hz(w_wr[0], w_rd[0], w_wr[2], w_rd[2])
                     | waw_hz(w_wr[1], w_rd[1], w_wr[2], w_rd[2]);

endmodule

// File: rtl/dec_rv_ssc_bundler.sv
// Instruction bundler: circular word queue feeding a 1..3 lane issue bundle register.
// Lanes B/C are filled greedily from the queue head when the hazard checker allows.
module dec_rv_ssc_bundler
   import dec_rv_ssc_bundler_pkg::*;
#(
   parameter int QDEPTH = QDEPTH_DEF
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        flush,
   input  logic        inValid,
   input  logic [31:0] inWord,
   output logic        inReady,
   output logic        outValid,
   output logic [31:0] outWordA,
   output logic [31:0] outWordB,
   output logic [31:0] outWordC,
   output logic [1:0]  outCount,
   input  logic        outReady
);

   localparam int          PW       = $clog2(QDEPTH);
   localparam logic [PW:0] OCC_FULL = (PW+1)'(QDEPTH);

   logic [31:0]   r_mem [QDEPTH];
   logic [PW-1:0] r_head, r_tail;
   logic [PW:0]   r_occ;

   bundle_state_e r_state, w_state_nx;
   lane_cnt_e     r_count, w_count_nx, w_pop_cnt;
   logic [31:0]   r_word_a, r_word_b, r_word_c;
   logic [31:0]   w_word_a_nx, w_word_b_nx, w_word_c_nx;

   logic [31:0]   w_h0, w_h1, w_h2;
   logic [3:0]    w_block;
   logic          w_push, w_take_b, w_take_c;

   assign w_h0 = r_mem[r_head];
   assign w_h1 = r_mem[r_head + PW'(1)];
   assign w_h2 = r_mem[r_head + PW'(2)];

   dec_rv_ssc_pair_chk u_pair_chk (
      .i_word_a (w_h0),
      .i_word_b (w_h1),
      .i_word_c (w_h2),
      .o_block  (w_block)
   );

   // Ready comes from registered occupancy only; a pop this cycle frees no slot yet
   assign inReady = (r_occ < OCC_FULL);
   assign w_push  = inValid && inReady && !flush;

   assign w_take_b = (r_occ >= (PW+1)'(2)) && (w_h0[1:0] == 2'b11) && (w_h1[1:0] == 2'b11)
                   && !is_ctrl(w_h0[6:2]) && (w_block[1:0] == 2'b00);
   assign w_take_c = w_take_b && (r_occ >= (PW+1)'(3)) && (w_h2[1:0] == 2'b11)
                   && !is_ctrl(w_h1[6:2]) && (w_block[3:2] == 2'b00);

   // NOTE: every variable gets a default at the top so no path leaves it unassigned (no latch).
   always_comb begin
      w_state_nx  = r_state;
      w_count_nx  = r_count;
      w_word_a_nx = r_word_a;
      w_word_b_nx = r_word_b;
      w_word_c_nx = r_word_c;
      w_pop_cnt   = CNT_NONE;
      if ((r_state == ST_EMPTY) || outReady) begin
         if (r_occ != '0) begin
            w_state_nx  = ST_HELD;
            w_word_a_nx = w_h0;
            w_word_b_nx = w_take_b ? w_h1 : 32'd0;
            w_word_c_nx = w_take_c ? w_h2 : 32'd0;
            w_count_nx  = w_take_c ? CNT_THREE : (w_take_b ? CNT_TWO : CNT_ONE);
            w_pop_cnt   = w_count_nx;
         end else begin
            w_state_nx  = ST_EMPTY;
            w_word_a_nx = 32'd0;
            w_word_b_nx = 32'd0;
            w_word_c_nx = 32'd0;
            w_count_nx  = CNT_NONE;
         end
      end
   end

   // NOTE: state registers use non-blocking assignments so all of them update together at the edge.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_state  <= ST_EMPTY;
         r_count  <= CNT_NONE;
         r_word_a <= '0;
         r_word_b <= '0;
         r_word_c <= '0;
         r_head   <= '0;
         r_tail   <= '0;
         r_occ    <= '0;
      end else if (flush) begin
         r_state  <= ST_EMPTY;
         r_count  <= CNT_NONE;
         r_word_a <= '0;
         r_word_b <= '0;
         r_word_c <= '0;
         r_head   <= '0;
         r_tail   <= '0;
         r_occ    <= '0;
      end else begin
         r_state  <= w_state_nx;
         r_count  <= w_count_nx;
         r_word_a <= w_word_a_nx;
         r_word_b <= w_word_b_nx;
         r_word_c <= w_word_c_nx;
         r_head   <= r_head + PW'(w_pop_cnt);
         r_tail   <= r_tail + PW'(w_push);
         r_occ    <= r_occ + (PW+1)'(w_push) - (PW+1)'(w_pop_cnt);
      end
   end

   // NOTE: queue storage has no reset; occupancy alone decides which entries are live.
   always_ff @(posedge clock) begin
      if (w_push) r_mem[r_tail] <= inWord;
   end

   assign outValid = (r_state == ST_HELD);
   assign outCount = r_count;
   assign outWordA = r_word_a;
   assign outWordB = r_word_b;
   assign outWordC = r_word_c;

endmodule

// File: tb/tb_dec_rv_ssc_bundler.sv
// Bench for dec_rv_ssc_bundler: queue-based reference model compared every cycle,
// plus directed scenarios with hand-encoded instruction words.
module tb_dec_rv_ssc_bundler;

   localparam int QD = 4;

   localparam logic [31:0] NOP       = 32'h0000_0013; // addi x0,x0,0
   localparam logic [31:0] ADD_10_11 = 32'h00C5_8533; // add x10,x11,x12
   localparam logic [31:0] ADD_13_14 = 32'h00F7_06B3; // add x13,x14,x15
   localparam logic [31:0] ADD_16_17 = 32'h0128_8833; // add x16,x17,x18
   localparam logic [31:0] ADD_11_10 = 32'h00A5_05B3; // add x11,x10,x10
   localparam logic [31:0] BEQ_1_2   = 32'h0020_8463; // beq x1,x2,+8
   localparam logic [31:0] ADD_5_6   = 32'h0073_02B3; // add x5,x6,x7

   logic        clock = 1'b0;
   logic        reset;
   logic        flush, inValid, outReady;
   logic [31:0] inWord;
   logic        inReady, outValid;
   logic [31:0] outWordA, outWordB, outWordC;
   logic [1:0]  outCount;

   int n_checks = 0;
   int n_pass   = 0;

   dec_rv_ssc_bundler #(.QDEPTH(QD)) dut (
      .clock    (clock),
      .reset    (reset),
      .flush    (flush),
      .inValid  (inValid),
      .inWord   (inWord),
      .inReady  (inReady),
      .outValid (outValid),
      .outWordA (outWordA),
      .outWordB (outWordB),
      .outWordC (outWordC),
      .outCount (outCount),
      .outReady (outReady)
   );

   always #5 clock = ~clock;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   // ---------------- reference model: a word queue plus the bundle on the outputs
   logic [31:0] mq[$];
   logic        m_valid = 1'b0;
   int          m_cnt   = 0;
   logic [31:0] m_lane [3] = '{default: 32'd0};

   function automatic logic [4:0] op(input logic [31:0] w);
      return w[6:2];
   endfunction
   function automatic bit is32(input logic [31:0] w);
      return w[1:0] == 2'b11;
   endfunction
   function automatic bit ctrl(input logic [31:0] w);
      return op(w) inside {5'b11000, 5'b11001, 5'b11011, 5'b11100};
   endfunction
   function automatic logic [4:0] dst(input logic [31:0] w);
      return (op(w) inside {5'b11000, 5'b01000}) ? 5'd0 : w[11:7];
   endfunction
   function automatic logic [4:0] src1(input logic [31:0] w);
      return (op(w) inside {5'b01101, 5'b00101, 5'b11011}) ? 5'd0 : w[19:15];
   endfunction
   function automatic logic [4:0] src2(input logic [31:0] w);
      return (op(w) inside {5'b01100, 5'b11000, 5'b01000}) ? w[24:20] : 5'd0;
   endfunction
   // later word c conflicts with earlier word p on a register p writes
   function automatic bit hz(input logic [31:0] p, input logic [31:0] c);
      logic [4:0] d;
      d = dst(p);
      return (d != 5'd0) && (d == src1(c) || d == src2(c) || d == dst(c));
   endfunction

   function automatic int bundle_len();
      int n;
      n = 1;
      if (mq.size() >= 2 && is32(mq[0]) && is32(mq[1]) && !ctrl(mq[0]) && !hz(mq[0], mq[1]))
         n = 2;
      if (n == 2 && mq.size() >= 3 && is32(mq[2]) && !ctrl(mq[1])
          && !hz(mq[0], mq[2]) && !hz(mq[1], mq[2]))
         n = 3;
      return n;
   endfunction

   always @(posedge clock or posedge reset) begin
      bit acc;
      if (reset) begin
         mq.delete();
         m_valid = 1'b0;
         m_cnt   = 0;
         m_lane  = '{default: 32'd0};
      end else begin
         acc = inValid && (mq.size() < QD);
         if (flush) begin
            mq.delete();
            m_valid = 1'b0;
            m_cnt   = 0;
            m_lane  = '{default: 32'd0};
         end else begin
            if (!m_valid || outReady) begin
               m_lane = '{default: 32'd0};
               if (mq.size() > 0) begin
                  m_cnt = bundle_len();
                  for (int i = 0; i < m_cnt; i++) m_lane[i] = mq.pop_front();
                  m_valid = 1'b1;
               end else begin
                  m_valid = 1'b0;
                  m_cnt   = 0;
               end
            end
            if (acc) mq.push_back(inWord);
         end
      end
   end

   // ---------------- per-cycle compare and issued-word log, sampled mid-cycle
   logic [31:0] issued[$];

   always @(negedge clock) begin
      check("cycle", {inReady, outValid, outCount, outWordA, outWordB, outWordC},
            {1'(mq.size() < QD), m_valid, 2'(m_cnt), m_lane[0], m_lane[1], m_lane[2]});
      if (outValid && outReady && !reset) begin
         if (outCount >= 2'd1) issued.push_back(outWordA);
         if (outCount >= 2'd2) issued.push_back(outWordB);
         if (outCount >= 2'd3) issued.push_back(outWordC);
      end
   end

   // ---------------- stimulus helpers (all called at posedge + 1)
   task automatic step(input int n);
      repeat (n) @(posedge clock);
      #1;
   endtask

   task automatic push_word(input logic [31:0] w);
      logic acc;
      acc     = 1'b0;
      inValid = 1'b1;
      inWord  = w;
      for (int k = 0; k < 40 && !acc; k++) begin
         @(negedge clock);
         acc = inReady;
         @(posedge clock);
         #1;
      end
      inValid = 1'b0;
      check("push_accept", {127'd0, acc}, 128'd1);
   endtask

   task automatic check_bundle(input string name, input logic [1:0] cnt,
                               input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
      check(name, {outValid, outCount, outWordA, outWordB, outWordC}, {1'b1, cnt, a, b, c});
   endtask

   function automatic logic [31:0] enc_add(input int rd);
      return {7'd0, 5'd0, 5'd0, 3'd0, 5'(rd), 7'b0110011};
   endfunction

   logic [31:0] fill_w [6];

   initial begin
      reset = 1'b1; flush = 1'b0; inValid = 1'b0; inWord = '0; outReady = 1'b0;
      #1;
      check("reset_outputs", {inReady, outValid, outCount, outWordA, outWordB, outWordC}, {1'b1, 1'b0, 98'd0});
      step(3);
      reset = 1'b0;

      // back-to-back stream from empty: two-edge latency, each word issued as it arrives
      outReady = 1'b1;
      push_word(ADD_10_11);
      check("latency_one_edge", {127'd0, outValid}, 128'd0);
      push_word(ADD_13_14);
      check_bundle("latency_two_edge", 2'd1, ADD_10_11, 32'd0, 32'd0);
      push_word(ADD_16_17);
      step(4);

      // three independent ADDs queued behind a held bundle issue as one triple
      outReady = 1'b0;
      push_word(NOP); push_word(ADD_10_11); push_word(ADD_13_14); push_word(ADD_16_17);
      check_bundle("held_nop", 2'd1, NOP, 32'd0, 32'd0);
      outReady = 1'b1;
      step(1);
      check_bundle("triple", 2'd3, ADD_10_11, ADD_13_14, ADD_16_17);
      step(1);
      check("drained_empty", {127'd0, outValid}, 128'd0);

      // RAW x10 splits the pair
      outReady = 1'b0;
      push_word(NOP); push_word(ADD_10_11); push_word(ADD_11_10);
      outReady = 1'b1;
      step(1);
      check_bundle("raw_first", 2'd1, ADD_10_11, 32'd0, 32'd0);
      step(1);
      check_bundle("raw_second", 2'd1, ADD_11_10, 32'd0, 32'd0);
      step(2);

      // branch in lane A issues alone
      outReady = 1'b0;
      push_word(NOP); push_word(BEQ_1_2); push_word(ADD_5_6);
      outReady = 1'b1;
      step(1);
      check_bundle("beq_alone", 2'd1, BEQ_1_2, 32'd0, 32'd0);
      step(1);
      check_bundle("add_after_beq", 2'd1, ADD_5_6, 32'd0, 32'd0);
      step(2);

      // fill the queue with outReady low, then drain with no loss or duplication
      issued.delete();
      for (int i = 0; i < 6; i++) fill_w[i] = enc_add(i + 1);
      outReady = 1'b0;
      for (int i = 0; i < 5; i++) push_word(fill_w[i]);
      check("full_in_ready", {127'd0, inReady}, 128'd0);
      check_bundle("full_held", 2'd1, fill_w[0], 32'd0, 32'd0);
      inValid = 1'b1; inWord = fill_w[5];
      step(3);
      check_bundle("frozen_held", 2'd1, fill_w[0], 32'd0, 32'd0);
      outReady = 1'b1;
      push_word(fill_w[5]);
      step(6);
      check("drain_count", 128'(issued.size()), 128'd6);
      for (int i = 0; i < 6 && i < issued.size(); i++)
         check($sformatf("drain_word%0d", i), {96'd0, issued[i]}, {96'd0, fill_w[i]});

      // flush with a concurrent push and a held bundle
      outReady = 1'b0;
      push_word(ADD_5_6); push_word(ADD_10_11);
      flush = 1'b1; inValid = 1'b1; inWord = ADD_13_14;
      step(1);
      flush = 1'b0; inValid = 1'b0;
      check("flush_state", {inReady, outValid, outCount}, {1'b1, 1'b0, 2'd0});
      outReady = 1'b1;
      push_word(ADD_16_17);
      step(1);
      check_bundle("after_flush", 2'd1, ADD_16_17, 32'd0, 32'd0);
      step(2);

      // reset between edges while holding a bundle
      outReady = 1'b0;
      push_word(NOP); push_word(ADD_10_11);
      #2;
      reset = 1'b1;
      #1;
      check("reset_mid_cycle", {inReady, outValid, outCount, outWordA}, {1'b1, 1'b0, 2'd0, 32'd0});
      @(posedge clock); #1;
      reset = 1'b0;
      outReady = 1'b1;
      push_word(ADD_13_14);
      step(1);
      check_bundle("after_reset", 2'd1, ADD_13_14, 32'd0, 32'd0);
      step(3);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
